// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer_if
//  Description : Push, pop and hazard-lookup bundle of the store buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface store_buffer_if;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_addr;
    logic [1:0]  push_size;
    logic [31:0] push_data;
    logic        push_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [1:0]  out_size;
    logic [31:0] out_data;
    logic        chk_valid;
    logic [31:0] chk_addr;
    logic        chk_hit;
    logic        empty;

    modport master (
        output push_valid, push_addr, push_size, push_data, out_ready,
               chk_valid, chk_addr,
        input  push_ready, push_err, out_valid, out_addr, out_size, out_data,
               chk_hit, empty
    );

    modport slave (
        input  push_valid, push_addr, push_size, push_data, out_ready,
               chk_valid, chk_addr,
        output push_ready, push_err, out_valid, out_addr, out_size, out_data,
               chk_hit, empty
    );
endinterface
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer
//  Description : In-order FIFO of committed stores feeding the D-cache merge,
//                with a word-address hazard lookup for the load path.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  wire              clk,
    input  wire              rst,
    store_buffer_if.slave    bus
);
    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

    logic [31:0] r_addr_mem [DEPTH];
    logic [1:0]  r_size_mem [DEPTH];
    logic [31:0] r_data_mem [DEPTH];

    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic            r_push_err;

    logic [c_AW-1:0] w_wr_idx;
    logic [c_AW-1:0] w_rd_idx;
    logic [c_AW:0]   w_count;
    logic            w_full;
    logic            w_empty;
    logic            w_push_fire;
    logic            w_misaligned;
    logic            w_write;
    logic            w_pop;
    logic [DEPTH-1:0] w_match;

    assign w_wr_idx = r_wr_ptr[c_AW-1:0];
    assign w_rd_idx = r_rd_ptr[c_AW-1:0];
    assign w_count  = r_wr_ptr - r_rd_ptr;
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) && (w_wr_idx == w_rd_idx);

    // Misaligned stores are still handshaken so the MEM stage never stalls on them.
    assign w_misaligned = ((bus.push_size == 2'b01) && bus.push_addr[0]) ||
                          (bus.push_size[1] && (bus.push_addr[1:0] != 2'b00));
    assign w_push_fire  = bus.push_valid && !w_full;
    assign w_write      = w_push_fire && !w_misaligned;
    assign w_pop        = !w_empty && bus.out_ready;

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_addr_mem[w_wr_idx] <= bus.push_addr;
            r_size_mem[w_wr_idx] <= bus.push_size;
            r_data_mem[w_wr_idx] <= bus.push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_push_err <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_push_err <= w_push_fire && w_misaligned;
        end
    end

    // An entry is live when its distance from the head is below the occupancy.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            logic [c_AW-1:0] w_off;
            assign w_off = c_AW'(gi) - w_rd_idx;
            assign w_match[gi] = ({1'b0, w_off} < w_count) &&
                                 (r_addr_mem[gi][31:2] == bus.chk_addr[31:2]);
        end
    endgenerate

    assign bus.push_ready = !w_full;
    assign bus.push_err   = r_push_err;
    assign bus.out_valid  = !w_empty;
    assign bus.out_addr   = w_empty ? 32'h0 : r_addr_mem[w_rd_idx];
    assign bus.out_size   = w_empty ? 2'b00 : r_size_mem[w_rd_idx];
    assign bus.out_data   = w_empty ? 32'h0 : r_data_mem[w_rd_idx];
    assign bus.chk_hit    = bus.chk_valid && (|w_match);
    assign bus.empty      = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_buffer
//  Description : Scoreboard bench for store_buffer (DEPTH = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
    } entry_t;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;
    int   n_pops;
    entry_t r_sb_q[$];

    store_buffer_if sb ();

    store_buffer #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic v, input logic [31:0] a, input logic [1:0] s,
                              input logic [31:0] d);
        sb.push_valid = v;
        sb.push_addr  = a;
        sb.push_size  = s;
        sb.push_data  = d;
    endtask

    function automatic logic is_misaligned(input logic [31:0] a, input logic [1:0] s);
        return ((s == 2'b01) && a[0]) || (s[1] && (a[1:0] != 2'b00));
    endfunction

    // Scoreboard: accepted aligned pushes enqueue, observed pops dequeue and compare.
    always @(negedge clk) begin
        if (rst) begin
            r_sb_q.delete();
        end else begin
            if (sb.out_valid && sb.out_ready) begin
                n_pops++;
                if (r_sb_q.size() == 0) begin
                    check_val("pop_unexpected", 32'h1, 32'h0);
                end else begin
                    entry_t e;
                    e = r_sb_q.pop_front();
                    check_val("pop_addr", sb.out_addr, e.addr);
                    check_val("pop_size", {30'h0, sb.out_size}, {30'h0, e.size});
                    check_val("pop_data", sb.out_data, e.data);
                end
            end
            if (sb.push_valid && sb.push_ready && !is_misaligned(sb.push_addr, sb.push_size)) begin
                r_sb_q.push_back({sb.push_addr, sb.push_size, sb.push_data});
            end
        end
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        n_pops  = 0;
        rst = 1'b1;
        drive_push(1'b0, 32'h0, 2'b00, 32'h0);
        sb.out_ready = 1'b0;
        sb.chk_valid = 1'b0;
        sb.chk_addr  = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        sb.chk_valid = 1'b1;
        @(negedge clk);
        check_val("rst_push_ready", {31'h0, sb.push_ready}, 32'h1);
        check_val("rst_push_err",   {31'h0, sb.push_err},   32'h0);
        check_val("rst_out_valid",  {31'h0, sb.out_valid},  32'h0);
        check_val("rst_empty",      {31'h0, sb.empty},      32'h1);
        check_val("rst_out_addr",   sb.out_addr,            32'h0);
        check_val("rst_out_data",   sb.out_data,            32'h0);
        check_val("rst_chk_hit",    {31'h0, sb.chk_hit},    32'h0);

        // Word store, held at the head, then consumed.
        tick();
        sb.chk_valid = 1'b0;
        drive_push(1'b1, 32'h1000_0004, 2'b10, 32'hDEAD_BEEF);
        tick();
        drive_push(1'b0, 32'h0, 2'b00, 32'h0);
        @(negedge clk);
        check_val("word_out_valid", {31'h0, sb.out_valid}, 32'h1);
        check_val("word_out_addr",  sb.out_addr, 32'h1000_0004);
        check_val("word_out_data",  sb.out_data, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check_val("hold_valid", {31'h0, sb.out_valid}, 32'h1);
            check_val("hold_addr",  sb.out_addr, 32'h1000_0004);
            check_val("hold_data",  sb.out_data, 32'hDEAD_BEEF);
        end
        tick();
        sb.out_ready = 1'b1;
        tick();
        sb.out_ready = 1'b0;
        @(negedge clk);
        check_val("word_drained_empty", {31'h0, sb.empty}, 32'h1);

        // Fill with byte stores, attempt a fifth while popping, then drain.
        for (int i = 0; i < 4; i++) begin
            tick();
            drive_push(1'b1, 32'h20 + 32'(i), 2'b00, 32'h11 * 32'(i + 1));
        end
        tick();
        drive_push(1'b1, 32'h24, 2'b00, 32'h55);
        sb.out_ready = 1'b1;
        @(negedge clk);
        check_val("full_push_ready", {31'h0, sb.push_ready}, 32'h0);
        tick();
        drive_push(1'b0, 32'h0, 2'b00, 32'h0);
        tick();
        tick();
        tick();
        sb.out_ready = 1'b0;
        @(negedge clk);
        check_val("full_drained_empty", {31'h0, sb.empty}, 32'h1);

        // Wrap: one push and one pop per cycle.
        for (int i = 0; i < 10; i++) begin
            tick();
            drive_push(1'b1, 32'h200 + 32'(4 * i), 2'b10, 32'hA0 + 32'(i));
            sb.out_ready = 1'b1;
            @(negedge clk);
            check_val("wrap_push_ready", {31'h0, sb.push_ready}, 32'h1);
            if (i > 0) check_val("wrap_out_valid", {31'h0, sb.out_valid}, 32'h1);
        end
        tick();
        drive_push(1'b0, 32'h0, 2'b00, 32'h0);
        tick();
        sb.out_ready = 1'b0;
        @(negedge clk);
        check_val("wrap_empty", {31'h0, sb.empty}, 32'h1);

        // Hazard lookup.
        tick();
        drive_push(1'b1, 32'h80, 2'b01, 32'h1234);
        tick();
        drive_push(1'b0, 32'h0, 2'b00, 32'h0);
        sb.chk_valid = 1'b1;
        sb.chk_addr  = 32'h83;
        @(negedge clk);
        check_val("hz_same_word", {31'h0, sb.chk_hit}, 32'h1);
        sb.chk_addr = 32'h84;
        #1;
        check_val("hz_other_word", {31'h0, sb.chk_hit}, 32'h0);
        sb.chk_valid = 1'b0;
        sb.chk_addr  = 32'h80;
        #1;
        check_val("hz_no_valid", {31'h0, sb.chk_hit}, 32'h0);
        tick();
        drive_push(1'b1, 32'h84, 2'b10, 32'h5678);
        sb.chk_valid = 1'b1;
        sb.chk_addr  = 32'h84;
        @(negedge clk);
        check_val("hz_same_cycle_push", {31'h0, sb.chk_hit}, 32'h0);
        tick();
        drive_push(1'b0, 32'h0, 2'b00, 32'h0);
        @(negedge clk);
        check_val("hz_next_cycle", {31'h0, sb.chk_hit}, 32'h1);
        sb.chk_valid = 1'b0;
        sb.out_ready = 1'b1;
        tick();
        tick();
        sb.out_ready = 1'b0;
        @(negedge clk);
        check_val("hz_drained_empty", {31'h0, sb.empty}, 32'h1);

        // Misaligned half and word stores are accepted but dropped.
        for (int k = 0; k < 2; k++) begin
            tick();
            if (k == 0) drive_push(1'b1, 32'h101, 2'b01, 32'h99);
            else        drive_push(1'b1, 32'h102, 2'b10, 32'h77);
            @(negedge clk);
            check_val("mis_accepted", {31'h0, sb.push_ready}, 32'h1);
            tick();
            drive_push(1'b0, 32'h0, 2'b00, 32'h0);
            @(negedge clk);
            check_val("mis_err_pulse", {31'h0, sb.push_err}, 32'h1);
            check_val("mis_empty",     {31'h0, sb.empty},    32'h1);
            tick();
            @(negedge clk);
            check_val("mis_err_clear", {31'h0, sb.push_err}, 32'h0);
            check_val("mis_still_empty", {31'h0, sb.empty},  32'h1);
        end

        // Reset discards pending entries.
        for (int i = 0; i < 3; i++) begin
            tick();
            drive_push(1'b1, 32'h300 + 32'(4 * i), 2'b10, 32'hC0 + 32'(i));
        end
        tick();
        drive_push(1'b0, 32'h0, 2'b00, 32'h0);
        @(negedge clk);
        check_val("pend_not_empty", {31'h0, sb.empty}, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_mid_empty",     {31'h0, sb.empty},     32'h1);
        check_val("rst_mid_out_valid", {31'h0, sb.out_valid}, 32'h0);
        check_val("rst_mid_out_data",  sb.out_data,           32'h0);

        check_val("total_pops", 32'(n_pops), 32'd17);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
